bist_sync_controller: RTL and testbench

- BIST sequencer for the K/J synchronizer datapath.
- On a rising edge of bist_start it:
  - takes the synchronizer over (test mode);
  - resets the synchronizer;
  - drives it with LFSR pseudo-random in_k/in_j/in_en patterns for a fixed count;
  - compacts out_synced_d/out_sync_err_d into a MISR;
  - compares the final signature against a golden value and reports bist_end/pass_fail.
- Sits between the top-level pins and the synchronizer core. Outside test mode it is a transparent mux.

---
 rtl/bist_sync_controller_if.sv | 27 ++
 rtl/bist_sync_controller.sv | 110 +++++++++++
 tb/tb_bist_sync_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_sync_controller_if.sv
// Pin- and core-side signals of the K/J synchronizer BIST controller.
// The controller side is "master"; the pins/core environment is "slave".
interface bist_sync_controller_if;
    logic bist_start;
    logic in_k;
    logic in_j;
    logic in_en;
    logic cut_synced;
    logic cut_sync_err;
    logic cut_k;
    logic cut_j;
    logic cut_en;
    logic cut_rst_n;
    logic test_mode;
    logic bist_end;
    logic pass_fail;

    modport master (
        input  bist_start, in_k, in_j, in_en, cut_synced, cut_sync_err,
        output cut_k, cut_j, cut_en, cut_rst_n, test_mode, bist_end, pass_fail
    );

    modport slave (
        output bist_start, in_k, in_j, in_en, cut_synced, cut_sync_err,
        input  cut_k, cut_j, cut_en, cut_rst_n, test_mode, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_sync_controller.sv
// BIST sequencer for the K/J synchronizer: LFSR pattern drive, MISR compaction,
// golden-signature compare. Outside test mode the core inputs pass straight through.
module bist_sync_controller #(
    parameter int          N_PATTERNS = 1000,
    parameter int          CUT_LAT    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] MISR_SEED  = 16'h0000,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                   CLK,
    input  logic                   RST,
    bist_sync_controller_if.master bus
);
    localparam int CNT_MAX = (N_PATTERNS > CUT_LAT) ? N_PATTERNS : CUT_LAT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CUT_LAT - 1);
    localparam logic [CNT_W-1:0] CAP_START  = CNT_W'(CUT_LAT);

    typedef enum logic [2:0] {
        IDLE, INIT, RUN, FLUSH, COMPARE, DONE
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             test_mode_q;
    logic             cut_rst_n_q;
    logic             bist_end_q;
    logic             pass_fail_q;
    logic             start_pulse;

    assign start_pulse = bus.bist_start & ~start_q;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign misr_d = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
                  ^ {14'b0, bus.cut_sync_err, bus.cut_synced};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            misr_q      <= MISR_SEED;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            test_mode_q <= 1'b0;
            cut_rst_n_q <= 1'b1;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            start_q <= bus.bist_start;
            case (state_q)
                IDLE, DONE: begin
                    // Everything INIT needs is loaded on entry so INIT's outputs are registered.
                    if (start_pulse) begin
                        state_q     <= INIT;
                        test_mode_q <= 1'b1;
                        cut_rst_n_q <= 1'b0;
                        bist_end_q  <= 1'b0;
                        pass_fail_q <= 1'b0;
                        lfsr_q      <= LFSR_SEED;
                        misr_q      <= MISR_SEED;
                        cnt_q       <= '0;
                    end
                end
                INIT: begin
                    cut_rst_n_q <= 1'b1;
                    state_q     <= RUN;
                end
                RUN: begin
                    lfsr_q <= lfsr_d;
                    // Core responses lag the patterns by CUT_LAT cycles.
                    if (cnt_q >= CAP_START) misr_q <= misr_d;
                    if (cnt_q == RUN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (CUT_LAT == 0) ? COMPARE : FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FLUSH: begin
                    misr_q <= misr_d;
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= COMPARE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                COMPARE: begin
                    pass_fail_q <= (misr_q == GOLDEN_SIG);
                    bist_end_q  <= 1'b1;
                    test_mode_q <= 1'b0;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Patterns only reach the core in RUN; INIT/FLUSH/COMPARE hold its inputs low.
    assign bus.cut_k     = test_mode_q ? ((state_q == RUN) & lfsr_q[0]) : bus.in_k;
    assign bus.cut_j     = test_mode_q ? ((state_q == RUN) & lfsr_q[1]) : bus.in_j;
    assign bus.cut_en    = test_mode_q ? ((state_q == RUN) & lfsr_q[2]) : bus.in_en;
    assign bus.cut_rst_n = cut_rst_n_q;
    assign bus.test_mode = test_mode_q;
    assign bus.bist_end  = bist_end_q;
    assign bus.pass_fail = pass_fail_q;
endmodule

// File: tb/tb_bist_sync_controller.sv
// Bench for bist_sync_controller: behavioural K/J synchronizer as the core,
// signature reference model, and a scoreboard checked on each bist_end rise.
module tb_bist_sync_controller;
    localparam int          N     = 200;
    localparam int          LAT   = 2;
    localparam logic [15:0] LSEED = 16'hACE1;
    localparam logic [15:0] MSEED = 16'h0000;

    function automatic logic jk_next(input logic q, input logic k, input logic j, input logic en);
        logic r;
        r = q;
        if (en) begin
            if (j && !k) r = 1'b1;
            else if (k && !j) r = 1'b0;
            else if (k && j) r = ~q;
        end
        return r;
    endfunction

    // Signature of the core's response stream to patterns 0..N-1, with an optional stuck fault.
    function automatic logic [15:0] ref_sig(input int fault);
        logic [15:0] l, m;
        logic q, syn, err;
        l = LSEED;
        m = MSEED;
        q = 1'b0;
        for (int i = 0; i < N; i++) begin
            q   = jk_next(q, l[0], l[1], l[2]);
            err = l[0] & l[1] & l[2];
            syn = q;
            if (fault == 1) syn = 1'b0;
            if (fault == 2) err = 1'b1;
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {14'b0, err, syn};
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = ref_sig(0);

    logic CLK = 1'b0;
    logic RST = 1'b0;
    bist_sync_controller_if bus();

    bist_sync_controller #(
        .N_PATTERNS(N), .CUT_LAT(LAT), .LFSR_SEED(LSEED), .MISR_SEED(MSEED), .GOLDEN_SIG(GOLD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Behavioural synchronizer core with two-cycle output latency.
    int   fault = 0;
    logic q_c = 1'b0, syn0 = 1'b0, err0 = 1'b0, syn1 = 1'b0, err1 = 1'b0;
    always @(posedge CLK) begin
        if (!bus.cut_rst_n) begin
            q_c <= 1'b0; syn0 <= 1'b0; err0 <= 1'b0; syn1 <= 1'b0; err1 <= 1'b0;
        end else begin
            q_c  <= jk_next(q_c, bus.cut_k, bus.cut_j, bus.cut_en);
            syn0 <= jk_next(q_c, bus.cut_k, bus.cut_j, bus.cut_en);
            err0 <= bus.cut_k & bus.cut_j & bus.cut_en;
            syn1 <= syn0;
            err1 <= err0;
        end
    end
    assign bus.cut_synced   = (fault == 1) ? 1'b0 : syn1;
    assign bus.cut_sync_err = (fault == 2) ? 1'b1 : err1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int   end_cyc;
        logic pf;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic end_prev = 1'b0;

    always @(negedge CLK) begin
        if (bus.bist_end === 1'b1 && end_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_end: bist_end rose at cycle %0d with no run pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("end_latency", cyc, mon_e.end_cyc);
                check("pass_fail", {31'b0, bus.pass_fail}, {31'b0, mon_e.pf});
            end
        end
        end_prev = bus.bist_end;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic drive_random_pins();
        bus.in_k  = 1'($urandom);
        bus.in_j  = 1'($urandom);
        bus.in_en = 1'($urandom);
    endtask

    task automatic check_passthrough(input string name);
        check(name, {29'b0, bus.cut_en, bus.cut_j, bus.cut_k}, {29'b0, bus.in_en, bus.in_j, bus.in_k});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_test_mode"}, {31'b0, bus.test_mode}, 32'd0);
        check({name, "_bist_end"},  {31'b0, bus.bist_end},  32'd0);
        check({name, "_pass_fail"}, {31'b0, bus.pass_fail}, 32'd0);
        check({name, "_cut_rst_n"}, {31'b0, bus.cut_rst_n}, 32'd1);
        check_passthrough({name, "_passthru"});
    endtask

    // Produces a fresh 0->1 edge and queues the result the run must report.
    task automatic start_run(input int flt);
        exp_t e;
        @(negedge CLK);
        bus.bist_start = 1'b0;
        fault = flt;
        @(negedge CLK);
        bus.bist_start = 1'b1;
        e.end_cyc = cyc + 1 + 2 + N + LAT;
        e.pf      = (ref_sig(flt) == GOLD);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2 * N + 100) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL run_timeout: %0d runs still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    logic [15:0] ls;
    logic        exp_pf;

    initial begin
        bus.bist_start = 1'b0;
        bus.in_k = 1'b0; bus.in_j = 1'b0; bus.in_en = 1'b0;
        ls = LSEED;

        // Reset held with random pins and start toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive_random_pins();
            bus.bist_start = 1'($urandom);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge CLK);
        bus.bist_start = 1'b0;
        RST = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive_random_pins();
            #1;
            check_passthrough("idle_passthru");
            check("idle_test_mode", {31'b0, bus.test_mode}, 32'd0);
        end

        // Golden run with start held high and an extra pulse mid-RUN.
        start_run(0);
        @(posedge CLK); #1;
        check("init_cut_rst_n", {31'b0, bus.cut_rst_n}, 32'd0);
        check("init_test_mode", {31'b0, bus.test_mode}, 32'd1);
        check("init_bist_end",  {31'b0, bus.bist_end},  32'd0);
        @(posedge CLK); #1;
        check("run_cut_rst_n", {31'b0, bus.cut_rst_n}, 32'd1);
        check("first_pattern", {29'b0, bus.cut_en, bus.cut_j, bus.cut_k}, {29'b0, ls[2:0]});
        tick($urandom_range(10, 150));
        @(negedge CLK);
        bus.bist_start = 1'b0;
        @(negedge CLK);
        bus.bist_start = 1'b1;
        wait_done();

        exp_pf = (ref_sig(0) == GOLD);
        tick(5);
        #1;
        check("done_hold_end",  {31'b0, bus.bist_end},  32'd1);
        check("done_hold_pf",   {31'b0, bus.pass_fail}, {31'b0, exp_pf});
        check("done_test_mode", {31'b0, bus.test_mode}, 32'd0);
        @(negedge CLK);
        drive_random_pins();
        #1;
        check_passthrough("done_passthru");

        // Rerun from DONE: bist_end clears in INIT.
        start_run(0);
        @(posedge CLK); #1;
        check("rerun_clear_end", {31'b0, bus.bist_end}, 32'd0);
        wait_done();

        // Stuck-at faults on the core outputs.
        start_run(1);
        wait_done();
        start_run(2);
        wait_done();

        // Reset mid-run aborts; the following run must reproduce the golden result.
        start_run(0);
        tick(1 + N / 2);
        @(negedge CLK);
        sb.delete();
        drive_random_pins();
        RST = 1'b0;
        bus.bist_start = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge CLK);
        RST = 1'b1;
        start_run(0);
        wait_done();

        // Random fault mix.
        for (int i = 0; i < 3; i++) begin
            start_run(int'($urandom_range(0, 2)));
            wait_done();
        end
        fault = 0;

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
